// File: rtl/mem_stage_pkg.sv
// Shared inst short codes, FSM states and helpers for mem_stage.
// Codes 1..31 are non-memory ops with writeback; 32..39 are loads/stores.
package mem_stage_pkg;

  localparam int INST_CODE_W = 6;

  typedef logic [INST_CODE_W-1:0] inst_t;

  localparam inst_t instNOP   = 6'd0;
  localparam inst_t instLUI   = 6'd1;
  localparam inst_t instAUIPC = 6'd2;
  localparam inst_t instADD   = 6'd3;
  localparam inst_t instSUB   = 6'd4;
  localparam inst_t instAND   = 6'd5;
  localparam inst_t instOR    = 6'd6;
  localparam inst_t instXOR   = 6'd7;
  localparam inst_t instALU_LAST = 6'd31;

  localparam inst_t instLB  = 6'd32;
  localparam inst_t instLH  = 6'd33;
  localparam inst_t instLW  = 6'd34;
  localparam inst_t instLBU = 6'd35;
  localparam inst_t instLHU = 6'd36;
  localparam inst_t instSB  = 6'd37;
  localparam inst_t instSH  = 6'd38;
  localparam inst_t instSW  = 6'd39;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } mem_state_e;

  function automatic logic is_load(inst_t i);
    return i inside {instLB, instLH, instLW,
                     instLBU, instLHU};
  endfunction

  function automatic logic is_store(inst_t i);
    return i inside {instSB, instSH, instSW};
  endfunction

  function automatic logic is_mem(inst_t i);
    return is_load(i) || is_store(i);
  endfunction

  function automatic logic is_wb_alu(inst_t i);
    return (i != instNOP) && (i <= instALU_LAST);
  endfunction

  // Access size minus one, i.e. index of the last byte.
  function automatic logic [1:0] size_m1(inst_t i);
    logic [1:0] r;
    r = 2'd3;
    if (i inside {instLB, instLBU, instSB})
      r = 2'd0;
    else if (i inside {instLH, instLHU, instSH})
      r = 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extension: turns the assembled little-endian buffer into
// the writeback word. Ports: buf_i buffer, inst_i op code, data_o result.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] buf_i,
  input  inst_t       inst_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = 32'b0;
    case (inst_i)
      instLB:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      instLBU: data_o = {24'b0, buf_i[7:0]};
      instLH:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      instLHU: data_o = {16'b0, buf_i[15:0]};
      instLW:  data_o = buf_i;
      default: data_o = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over the 8-bit mctl port.
// Ports: ex_mem bundle in, mctl req/ack port, mem_wb/forward/stall out.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int INST_W = INST_CODE_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic [4:0]        rd_address_in,
  input  logic [31:0]       rd_data_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic [31:0]       mem_address_in,
  output logic              mctl_req,
  output logic              mctl_we,
  output logic [31:0]       mctl_addr,
  output logic [7:0]        mctl_wdata,
  input  logic              mctl_ack,
  input  logic [7:0]        mctl_rdata,
  output logic [4:0]        rd_address_out,
  output logic [31:0]       rd_data_out,
  output logic              mem_rd_done,
  output logic              stall_req
);

  mem_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       buf_q, buf_d;
  logic [4:0]        rd_q, rd_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic [4:0]  rda_hold_q;
  logic [31:0] rdd_hold_q;
  logic        done_hold_q;
  logic        stall_hold_q;

  logic        req_c, we_c;
  logic [31:0] addr_c;
  logic [7:0]  wdata_c;
  logic [4:0]  rda_c;
  logic [31:0] rdd_c;
  logic        done_c, stall_c;

  logic [31:0] ext_data;
  logic        last_byte;

  mem_load_ext u_ext (
    .buf_i  (buf_q),
    .inst_i (inst_q),
    .data_o (ext_data)
  );

  assign last_byte = (cnt_q == size_m1(inst_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    buf_d   = buf_q;
    rd_d    = rd_q;
    inst_d  = inst_q;
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_mem(inst_in)) begin
            addr_d  = mem_address_in;
            data_d  = rd_data_in;
            rd_d    = rd_address_in;
            inst_d  = inst_in;
            cnt_d   = 2'd0;
            buf_d   = 32'b0;
            state_d = S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mctl_ack) begin
            if (is_load(inst_q))
              buf_d[{cnt_q, 3'b000} +: 8] = mctl_rdata;
            if (last_byte)
              state_d = S_DONE;
            else
              cnt_d = cnt_q + 2'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'b0;
    wdata_c = 8'b0;
    rda_c   = 5'b0;
    rdd_c   = 32'b0;
    stall_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem(inst_in)) begin
          stall_c = 1'b1;
        end else begin
          if (is_wb_alu(inst_in))
            rda_c = rd_address_in;
          rdd_c = rd_data_in;
        end
      end
      S_ACCESS: begin
        req_c   = 1'b1;
        we_c    = is_store(inst_q);
        addr_c  = addr_q + {30'b0, cnt_q};
        wdata_c = data_q[{cnt_q, 3'b000} +: 8];
        stall_c = 1'b1;
      end
      S_DONE: begin
        if (is_load(inst_q)) begin
          rda_c = rd_q;
          rdd_c = ext_data;
        end
      end
      default: ;
    endcase
    done_c = (rda_c != 5'd0);
    // The pass-through path is combinational, so force it quiet
    // while reset is held.
    if (!rst_n_in) begin
      rda_c   = 5'b0;
      rdd_c   = 32'b0;
      done_c  = 1'b0;
      stall_c = 1'b0;
    end
  end

  assign mctl_req   = rdy_in & req_c;
  assign mctl_we    = we_c;
  assign mctl_addr  = addr_c;
  assign mctl_wdata = wdata_c;

  // While frozen, the pipeline-facing outputs replay the last
  // value seen with rdy_in high.
  assign rd_address_out = rdy_in ? rda_c   : rda_hold_q;
  assign rd_data_out    = rdy_in ? rdd_c   : rdd_hold_q;
  assign mem_rd_done    = rdy_in ? done_c  : done_hold_q;
  assign stall_req      = rdy_in ? stall_c : stall_hold_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'b0;
      data_q  <= 32'b0;
      buf_q   <= 32'b0;
      rd_q    <= 5'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      rd_q    <= rd_d;
      inst_q  <= inst_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rda_hold_q   <= 5'b0;
      rdd_hold_q   <= 32'b0;
      done_hold_q  <= 1'b0;
      stall_hold_q <= 1'b0;
    end else if (rdy_in) begin
      rda_hold_q   <= rda_c;
      rdd_hold_q   <= rdd_c;
      done_hold_q  <= done_c;
      stall_hold_q <= stall_c;
    end
  end

endmodule
